// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants for the multiplier-sharing arbiter: FSM encoding and requester indices.
package mult_share_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_LAUNCH  = 2'b01;
  localparam logic [1:0] ST_WAIT    = 2'b10;
  localparam logic [1:0] ST_RESPOND = 2'b11;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return (owner == REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector; on a tie the requester that was not served last wins.
import mult_share_arbiter_pkg::*;

module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_owner
);

  always_comb begin
    o_valid = |i_req;
    o_owner = REQ0;
    if (i_req == 2'b11) begin
      o_owner = ~i_last;
    end else if (i_req[1]) begin
      o_owner = REQ1;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one start/done sequential multiplier between two requesters with round-robin
// arbitration and a watchdog that aborts an operation whose done never arrives.
import mult_share_arbiter_pkg::*;

module mult_share_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic [1:0]           i_req,
  input  logic [WIDTH-1:0]     i_a0,
  input  logic [WIDTH-1:0]     i_b0,
  input  logic [WIDTH-1:0]     i_a1,
  input  logic [WIDTH-1:0]     i_b1,
  output logic [1:0]           o_ack,
  output logic [2*WIDTH-1:0]   o_result,
  output logic                 o_err,
  output logic                 o_busy,
  output logic                 o_mul_start,
  output logic [WIDTH-1:0]     o_mul_a,
  output logic [WIDTH-1:0]     o_mul_b,
  input  logic                 i_mul_done,
  input  logic [2*WIDTH-1:0]   i_mul_product
);

  localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic               r_last;
  logic               r_owner;
  logic [WDOG_W-1:0]  r_wdog;
  logic [1:0]         r_ack;
  logic [2*WIDTH-1:0] r_result;
  logic               r_err;
  logic               r_busy;
  logic               r_mul_start;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               w_valid;
  logic               w_owner;

  rr_pick2 u_pick (
    .i_req   (i_req),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_owner (w_owner)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_valid) w_state_next = ST_LAUNCH;
      ST_LAUNCH:  w_state_next = ST_WAIT;
      ST_WAIT:    if (i_mul_done || (r_wdog == WDOG_LAST)) w_state_next = ST_RESPOND;
      ST_RESPOND: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Strobe outputs are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_last      <= REQ1;
      r_owner     <= REQ0;
      r_wdog      <= '0;
      r_ack       <= 2'b00;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_busy      <= (w_state_next != ST_IDLE);
      r_mul_start <= (w_state_next == ST_LAUNCH);
      r_ack       <= (w_state_next == ST_RESPOND) ? owner_onehot(r_owner) : 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_owner <= w_owner;
            r_mul_a <= (w_owner == REQ1) ? i_a1 : i_a0;
            r_mul_b <= (w_owner == REQ1) ? i_b1 : i_b0;
          end
        end
        ST_LAUNCH: r_wdog <= '0;
        ST_WAIT: begin
          if (r_wdog != WDOG_MAX) r_wdog <= r_wdog + 1'b1;
          if (i_mul_done) begin
            r_result <= i_mul_product;
            r_err    <= 1'b0;
          end else if (r_wdog == WDOG_LAST) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        ST_RESPOND: r_last <= r_owner;
        default: ;
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_result    = r_result;
  assign o_err       = r_err;
  assign o_busy      = r_busy;
  assign o_mul_start = r_mul_start;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: transaction-timeline model checked every cycle, directed scenarios, then random traffic.
module tb_mult_share_arbiter;

  localparam int W  = 4;
  localparam int PW = 2 * W;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req;
  logic [W-1:0]  ra [2];
  logic [W-1:0]  rb [2];
  logic [1:0]    ack;
  logic [PW-1:0] result;
  logic          err, busy, mul_start;
  logic [W-1:0]  mul_a, mul_b;
  logic          mul_done;
  logic [PW-1:0] mul_product;
  logic          agent_done = 1'b0;
  logic          force_done = 1'b0;
  logic [PW-1:0] agent_prod = '0;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit rand_mode  = 0;
  int mul_delay  = 9;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  assign mul_done    = agent_done | force_done;
  assign mul_product = agent_prod;

  mult_share_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .i_reset_n     (reset_n),
    .i_req         (req),
    .i_a0          (ra[0]),
    .i_b0          (rb[0]),
    .i_a1          (ra[1]),
    .i_b1          (rb[1]),
    .o_ack         (ack),
    .o_result      (result),
    .o_err         (err),
    .o_busy        (busy),
    .o_mul_start   (mul_start),
    .o_mul_a       (mul_a),
    .o_mul_b       (mul_b),
    .i_mul_done    (mul_done),
    .i_mul_product (mul_product)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: each transaction is a timeline (start cycle, ack cycle) derived from the sampled inputs.
  bit            m_active = 0;
  int            m_start = 0, m_ack = -1, m_idle_from = 0;
  bit            m_owner = 0, m_last = 1;
  logic [W-1:0]  m_a = '0, m_b = '0;
  logic [PW-1:0] m_res = '0;
  bit            m_err = 0;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      m_active = 0; m_res = '0; m_err = 0; m_a = '0; m_b = '0; m_last = 1; m_idle_from = cyc;
    end else begin
      if (m_active && m_ack >= 0 && cyc == m_ack + 1) begin
        m_active = 0; m_last = m_owner; m_idle_from = cyc;
      end
      if (!m_active) begin
        if (cyc - 1 >= m_idle_from && req != 2'b00) begin
          m_owner  = (req == 2'b11) ? !m_last : req[1];
          m_a      = m_owner ? ra[1] : ra[0];
          m_b      = m_owner ? rb[1] : rb[0];
          m_start  = cyc;
          m_ack    = -1;
          m_active = 1;
        end
      end else if (m_ack < 0 && cyc >= m_start + 2) begin
        if (mul_done) begin
          m_ack = cyc; m_res = mul_product; m_err = 0;
        end else if (cyc == m_start + 1 + TO) begin
          m_ack = cyc; m_res = '0; m_err = 1;
        end
      end
    end
    check("busy", busy, m_active);
    check("mul_start", mul_start, m_active && cyc == m_start);
    check("ack", ack, (m_active && m_ack == cyc) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
    check("result", result, m_res);
    check("err", err, m_err);
    check("mul_a", mul_a, m_a);
    check("mul_b", mul_b, m_b);
  end

  // Bench multiplier: answers with the true product after a chosen delay, or never.
  int ag_start = -1;
  int ag_delay = 0;
  always @(negedge clk) begin
    agent_done = 1'b0;
    agent_prod = PW'($urandom);
    if (mul_start) begin
      ag_start = cyc;
      if (rand_mode) ag_delay = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(1, 12));
      else           ag_delay = mul_delay;
    end
    if (!busy) ag_start = -1;
    if (ag_start >= 0 && ag_delay >= 1 && cyc == ag_start + ag_delay) begin
      agent_done = 1'b1;
      agent_prod = PW'(mul_a) * PW'(mul_b);
    end else if (rand_mode && (ag_start < 0 || cyc == ag_start) && $urandom_range(0, 9) == 0) begin
      agent_done = 1'b1;
    end
  end

  // Random requesters: hold until acked, sometimes abandon early with changed operands.
  bit rq_hold [2];
  int rq_gap  [2];
  always @(negedge clk) begin
    if (rand_mode) begin
      reset_n = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < 2; i++) begin
        if (rq_hold[i]) begin
          if (ack[i]) begin
            rq_hold[i] = 0; req[i] = 1'b0; rq_gap[i] = $urandom_range(0, 3);
          end else if ($urandom_range(0, 99) < 2) begin
            rq_hold[i] = 0; req[i] = 1'b0; rq_gap[i] = $urandom_range(0, 5);
            ra[i] = W'($urandom); rb[i] = W'($urandom);
          end
        end else if (rq_gap[i] > 0) begin
          rq_gap[i]--;
        end else if ($urandom_range(0, 99) < 40) begin
          ra[i] = W'($urandom); rb[i] = W'($urandom);
          req[i] = 1'b1; rq_hold[i] = 1;
        end
      end
    end
  end

  task automatic wait_start(output int s);
    int n = 0;
    do begin @(negedge clk); n++; end while (mul_start !== 1'b1 && n < 100);
    check("start_seen", mul_start, 1'b1);
    s = cyc;
  endtask

  task automatic wait_ack(output int r);
    int n = 0;
    do begin @(negedge clk); n++; end while (ack === 2'b00 && n < 100);
    check("ack_seen", (ack != 2'b00), 1'b1);
    r = cyc;
  endtask

  initial begin
    int s, r, s2, c0;
    reset_n = 1'b0; req = 2'b00;
    ra[0] = '0; rb[0] = '0; ra[1] = '0; rb[1] = '0;
    rq_hold[0] = 0; rq_hold[1] = 0; rq_gap[0] = 0; rq_gap[1] = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", ack, 2'b00);
    check("rst_result", result, 8'd0);
    check("rst_mul_start", mul_start, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single request, multiplier done 9 cycles after start.
    ra[0] = 4'd3; rb[0] = 4'd5; req = 2'b01; c0 = cyc; mul_delay = 9;
    wait_start(s);
    check("req_to_start", s, c0 + 1);
    wait_ack(r);
    check("single_ack_time", r, s + 10);
    check("single_ack", ack, 2'b01);
    check("single_result", result, 8'd15);
    check("single_err", err, 1'b0);
    req = 2'b00;
    @(negedge clk);
    check("single_busy_after", busy, 1'b0);

    // Contention straight out of reset: requester 0 first.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ra[0] = 4'd7; rb[0] = 4'd9; ra[1] = 4'd15; rb[1] = 4'd15; req = 2'b11; mul_delay = 3;
    wait_start(s);
    wait_ack(r);
    check("cont_ack0", ack, 2'b01);
    check("cont_result0", result, 8'd63);
    req = 2'b10;
    wait_start(s2);
    check("cont_second_start", s2, r + 2);
    wait_ack(r);
    check("cont_ack1", ack, 2'b10);
    check("cont_result1", result, 8'd225);

    // Fairness with both requesters held high.
    ra[0] = 4'd2; rb[0] = 4'd3; ra[1] = 4'd4; rb[1] = 4'd5; req = 2'b11; mul_delay = 2;
    for (int i = 0; i < 4; i++) begin
      wait_ack(r);
      check("fair_order", ack, (i % 2 == 1) ? 2'b10 : 2'b01);
      check("fair_result", result, (i % 2 == 1) ? 8'd20 : 8'd6);
    end
    req = 2'b00;

    // Timeout, then a normal request.
    @(negedge clk);
    ra[0] = 4'd1; rb[0] = 4'd1; req = 2'b01; mul_delay = -1;
    wait_start(s);
    wait_ack(r);
    check("to_ack_time", r, s + 33);
    check("to_ack", ack, 2'b01);
    check("to_err", err, 1'b1);
    check("to_result", result, 8'd0);
    req = 2'b00; mul_delay = 4;
    @(negedge clk);
    ra[1] = 4'd6; rb[1] = 4'd7; req = 2'b10;
    wait_start(s);
    wait_ack(r);
    check("post_to_result", result, 8'd42);
    check("post_to_err", err, 1'b0);
    req = 2'b00;

    // Reset in the middle of WAIT aborts silently.
    @(negedge clk);
    ra[0] = 4'd5; rb[0] = 4'd5; req = 2'b01; mul_delay = -1;
    wait_start(s);
    repeat (3) @(negedge clk);
    reset_n = 1'b0; req = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_result", result, 8'd0);
    check("mid_rst_mul_a", mul_a, 4'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("mid_rst_no_ack", ack, 2'b00);
    end
    ra[0] = 4'd9; rb[0] = 4'd9; req = 2'b01; mul_delay = 2;
    wait_start(s);
    wait_ack(r);
    check("mid_rst_later_result", result, 8'd81);
    req = 2'b00;

    // Spurious done in IDLE and LAUNCH, operands changed after capture.
    @(negedge clk);
    force_done = 1'b1;
    repeat (2) @(negedge clk);
    force_done = 1'b0;
    check("spur_idle_busy", busy, 1'b0);
    ra[1] = 4'd3; rb[1] = 4'd4; req = 2'b10; mul_delay = 5;
    wait_start(s);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    ra[1] = 4'd15; rb[1] = 4'd15;
    check("spur_launch_no_ack", ack, 2'b00);
    check("capture_mul_a", mul_a, 4'd3);
    check("capture_mul_b", mul_b, 4'd4);
    wait_ack(r);
    check("spur_ack_time", r, s + 6);
    check("spur_result", result, 8'd12);
    req = 2'b00;

    // Random traffic against the model.
    @(negedge clk);
    rand_mode = 1;
    repeat (3000) @(negedge clk);
    rand_mode = 0;
    @(negedge clk);
    reset_n = 1'b1; req = 2'b00;
    repeat (60) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
